// File: rtl/apu_cmd_queue.sv
// APU front-end: command FIFO with optional empty-queue cut-through, bounded
// outstanding-request tracking and a registered in-order result return.
module apu_cmd_queue #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int NUM_OPS         = 3,
  parameter int DATA_W          = 32,
  parameter int OP_W            = 6,
  parameter int FLAGS_I_W       = 15,
  parameter int FLAGS_O_W       = 5,
  parameter bit BYPASS          = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 n_reset,
  input  logic                                 apu_req_i,
  output logic                                 apu_gnt_o,
  input  logic [NUM_OPS*DATA_W-1:0]            apu_operands_i,
  input  logic [OP_W-1:0]                      apu_op_i,
  input  logic [FLAGS_I_W-1:0]                 apu_flags_i,
  output logic                                 apu_rvalid_o,
  output logic [DATA_W-1:0]                    apu_result_o,
  output logic [FLAGS_O_W-1:0]                 apu_flags_o,
  output logic                                 cmd_valid_o,
  input  logic                                 cmd_ready_i,
  output logic [NUM_OPS*DATA_W-1:0]            cmd_operands_o,
  output logic [OP_W-1:0]                      cmd_op_o,
  output logic [FLAGS_I_W-1:0]                 cmd_flags_o,
  input  logic                                 rsp_valid_i,
  input  logic [DATA_W-1:0]                    rsp_result_i,
  input  logic [FLAGS_O_W-1:0]                 rsp_flags_i,
  output logic [$clog2(DEPTH):0]               occupancy_o,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o,
  output logic                                 err_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = AW + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int OPS_W = NUM_OPS * DATA_W;
  localparam int ENT_W = OPS_W + OP_W + FLAGS_I_W;

  localparam logic [OCC_W-1:0] DEPTH_C   = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0] OUT_ONE   = OUT_W'(1);
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1);

  logic [ENT_W-1:0] fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [OCC_W-1:0] occ_reg;
  logic [OUT_W-1:0] out_reg;
  logic             err_reg;
  logic             rvalid_reg;
  logic [DATA_W-1:0]    result_reg;
  logic [FLAGS_O_W-1:0] rflags_reg;

  logic             full, empty, gnt, accept, bypass_sel, push, pop, rsp_ok;
  logic [ENT_W-1:0] req_entry, cmd_entry;

  // Grant depends only on registered counts so it never loops through the CPU.
  assign full       = (occ_reg == DEPTH_C);
  assign empty      = (occ_reg == '0);
  assign gnt        = !full && (out_reg < MAX_OUT_C);
  assign accept     = apu_req_i && gnt;
  assign req_entry  = {apu_flags_i, apu_op_i, apu_operands_i};
  assign bypass_sel = BYPASS && empty;
  assign cmd_entry  = bypass_sel ? req_entry : fifo_mem[rd_ptr_reg];

  // A cut-through command taken immediately never occupies a FIFO slot.
  assign push   = accept && !(bypass_sel && cmd_ready_i);
  assign pop    = !empty && cmd_ready_i;
  assign rsp_ok = rsp_valid_i && (out_reg != '0);

  assign apu_gnt_o      = gnt;
  assign cmd_valid_o    = bypass_sel ? accept : !empty;
  assign cmd_operands_o = cmd_entry[OPS_W-1:0];
  assign cmd_op_o       = cmd_entry[OPS_W +: OP_W];
  assign cmd_flags_o    = cmd_entry[OPS_W+OP_W +: FLAGS_I_W];
  assign occupancy_o    = occ_reg;
  assign outstanding_o  = out_reg;
  assign err_o          = err_reg;
  assign apu_rvalid_o   = rvalid_reg;
  assign apu_result_o   = result_reg;
  assign apu_flags_o    = rflags_reg;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= req_entry;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
      out_reg    <= '0;
      err_reg    <= 1'b0;
      rvalid_reg <= 1'b0;
      result_reg <= '0;
      rflags_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;

      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + OCC_ONE;
        2'b01:   occ_reg <= occ_reg - OCC_ONE;
        default: occ_reg <= occ_reg;
      endcase

      case ({accept, rsp_ok})
        2'b10:   out_reg <= out_reg + OUT_ONE;
        2'b01:   out_reg <= out_reg - OUT_ONE;
        default: out_reg <= out_reg;
      endcase

      // A response with nothing outstanding is dropped and latched as an error.
      if (rsp_valid_i && (out_reg == '0)) err_reg <= 1'b1;

      rvalid_reg <= rsp_ok;
      if (rsp_ok) begin
        result_reg <= rsp_result_i;
        rflags_reg <= rsp_flags_i;
      end
    end
  end

endmodule

// File: tb/tb_apu_cmd_queue.sv
// Scenario bench for apu_cmd_queue: cut-through and FIFO builds side by side,
// with a command scoreboard queue and a model of the outstanding count.
module tb_apu_cmd_queue;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 8;
  localparam int NUM_OPS = 3;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 6;
  localparam int FI_W    = 15;
  localparam int FO_W    = 5;
  localparam int OPS_W   = NUM_OPS * DATA_W;
  localparam int ENT_W   = OPS_W + OP_W + FI_W;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  logic              req, gnt, rvalid, cmd_valid, cmd_ready, rsp_valid, err;
  logic [OPS_W-1:0]  operands, cmd_operands;
  logic [OP_W-1:0]   op, cmd_op;
  logic [FI_W-1:0]   flags_i, cmd_flags;
  logic [DATA_W-1:0] result, rsp_result;
  logic [FO_W-1:0]   flags_o, rsp_flags;
  logic [2:0]        occupancy;
  logic [3:0]        outstanding;

  logic              req0, gnt0, rvalid0, cmd_valid0, cmd_ready0, err0;
  logic [OPS_W-1:0]  operands0, cmd_operands0;
  logic [OP_W-1:0]   op0, cmd_op0;
  logic [FI_W-1:0]   flags_i0, cmd_flags0;
  logic [DATA_W-1:0] result0;
  logic [FO_W-1:0]   flags_o0;
  logic [2:0]        occupancy0;
  logic [3:0]        outstanding0;

  apu_cmd_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT), .BYPASS(1'b1)) u_dut (
    .clk(clk), .n_reset(n_reset),
    .apu_req_i(req), .apu_gnt_o(gnt), .apu_operands_i(operands), .apu_op_i(op),
    .apu_flags_i(flags_i), .apu_rvalid_o(rvalid), .apu_result_o(result), .apu_flags_o(flags_o),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_operands_o(cmd_operands),
    .cmd_op_o(cmd_op), .cmd_flags_o(cmd_flags),
    .rsp_valid_i(rsp_valid), .rsp_result_i(rsp_result), .rsp_flags_i(rsp_flags),
    .occupancy_o(occupancy), .outstanding_o(outstanding), .err_o(err)
  );

  apu_cmd_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT), .BYPASS(1'b0)) u_dut_fifo (
    .clk(clk), .n_reset(n_reset),
    .apu_req_i(req0), .apu_gnt_o(gnt0), .apu_operands_i(operands0), .apu_op_i(op0),
    .apu_flags_i(flags_i0), .apu_rvalid_o(rvalid0), .apu_result_o(result0), .apu_flags_o(flags_o0),
    .cmd_valid_o(cmd_valid0), .cmd_ready_i(cmd_ready0), .cmd_operands_o(cmd_operands0),
    .cmd_op_o(cmd_op0), .cmd_flags_o(cmd_flags0),
    .rsp_valid_i(1'b0), .rsp_result_i('0), .rsp_flags_i('0),
    .occupancy_o(occupancy0), .outstanding_o(outstanding0), .err_o(err0)
  );

  logic [ENT_W-1:0] cmd_obs;
  assign cmd_obs = {cmd_flags, cmd_op, cmd_operands};

  int checks = 0;
  int failures = 0;
  logic [ENT_W-1:0] cmd_q[$];
  int m_out = 0;
  logic [DATA_W-1:0] last_result = '0;

  function automatic logic [ENT_W-1:0] mk(input int n);
    logic [OPS_W-1:0] ops;
    ops[31:0]  = 32'h1000_0000 + 32'(n);
    ops[63:32] = ~32'(n);
    ops[95:64] = 32'(n * 3);
    return {15'(n * 7 + 1), 6'(n), ops};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic r, input logic [ENT_W-1:0] e);
    req = r;
    {flags_i, op, operands} = e;
  endtask

  task automatic drain();
    int guard = 0;
    while (m_out > 0 && guard < 20) begin
      rsp_valid = 1'b1;
      rsp_result = 32'h5000 + 32'(guard);
      last_result = rsp_result;
      step();
      m_out--;
      guard++;
    end
    rsp_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    checks++; if (outstanding !== 4'd0) begin failures++; $display("FAIL reset_out: got %0d expected 0", outstanding); end
    checks++; if ({rvalid, result, flags_o, err} !== '0) begin failures++; $display("FAIL reset_rsp: got rvalid=%b result=%h flags=%h err=%b expected all 0", rvalid, result, flags_o, err); end
    #2 n_reset = 1'b1;
    step();
    checks++; if (gnt !== 1'b1) begin failures++; $display("FAIL reset_gnt: got %b expected 1", gnt); end
    checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_cmd_valid: got %b expected 0", cmd_valid); end
  endtask

  task automatic test_bypass();
    logic [ENT_W-1:0] e;
    e = mk(5);
    e[31:0] = 32'h1234_5678;
    cmd_ready = 1'b1;
    drive_req(1'b1, e);
    #1;
    checks++; if (gnt !== 1'b1) begin failures++; $display("FAIL bypass_gnt: got %b expected 1", gnt); end
    checks++; if (cmd_valid !== 1'b1) begin failures++; $display("FAIL bypass_valid: got %b expected 1", cmd_valid); end
    checks++; if (cmd_op !== 6'h05 || cmd_operands[31:0] !== 32'h1234_5678) begin failures++; $display("FAIL bypass_cmd: got op=%h op0=%h expected op=05 op0=12345678", cmd_op, cmd_operands[31:0]); end
    step();
    m_out = 1;
    drive_req(1'b0, '0);
    rsp_valid = 1'b1; rsp_result = 32'h0000_CAFE; rsp_flags = 5'h03;
    #1;
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL bypass_occ: got %0d expected 0", occupancy); end
    checks++; if (outstanding !== 4'd1) begin failures++; $display("FAIL bypass_out: got %0d expected 1", outstanding); end
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL bypass_rvalid_early: got %b expected 0", rvalid); end
    step();
    rsp_valid = 1'b0;
    m_out = 0;
    last_result = 32'h0000_CAFE;
    checks++; if (rvalid !== 1'b1 || result !== 32'h0000_CAFE || flags_o !== 5'h03) begin failures++; $display("FAIL bypass_rsp: got rvalid=%b result=%h flags=%h expected 1 0000cafe 03", rvalid, result, flags_o); end
    step();
    checks++; if (rvalid !== 1'b0 || result !== 32'h0000_CAFE) begin failures++; $display("FAIL bypass_hold: got rvalid=%b result=%h expected 0 0000cafe", rvalid, result); end
    checks++; if (outstanding !== 4'd0) begin failures++; $display("FAIL bypass_out_done: got %0d expected 0", outstanding); end
  endtask

  task automatic test_fill();
    logic [ENT_W-1:0] e, exp_e;
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e = mk(16 + i);
      drive_req(1'b1, e);
      #1;
      checks++; if (gnt !== (i < DEPTH)) begin failures++; $display("FAIL fill_gnt[%0d]: got %b expected %b", i, gnt, (i < DEPTH)); end
      if (i < DEPTH) begin cmd_q.push_back(e); m_out++; end
      checks++; if (cmd_valid !== 1'b1 || cmd_obs !== cmd_q[0]) begin failures++; $display("FAIL fill_head[%0d]: got valid=%b op=%h expected 1 %h", i, cmd_valid, cmd_op, cmd_q[0][OPS_W +: OP_W]); end
      step();
    end
    drive_req(1'b0, '0);
    #1;
    checks++; if (occupancy !== 3'd4) begin failures++; $display("FAIL fill_occ: got %0d expected 4", occupancy); end
    checks++; if (gnt !== 1'b0) begin failures++; $display("FAIL fill_full_gnt: got %b expected 0", gnt); end
    repeat (2) begin
      step();
      checks++; if (cmd_valid !== 1'b1 || cmd_obs !== cmd_q[0]) begin failures++; $display("FAIL fill_stall: got valid=%b op=%h expected 1 %h", cmd_valid, cmd_op, cmd_q[0][OPS_W +: OP_W]); end
    end
    cmd_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      exp_e = cmd_q.pop_front();
      checks++; if (cmd_valid !== 1'b1 || cmd_obs !== exp_e) begin failures++; $display("FAIL fill_drain[%0d]: got valid=%b op=%h expected 1 %h", k, cmd_valid, cmd_op, exp_e[OPS_W +: OP_W]); end
      step();
    end
    checks++; if (occupancy !== 3'd0 || cmd_valid !== 1'b0) begin failures++; $display("FAIL fill_empty: got occ=%0d valid=%b expected 0 0", occupancy, cmd_valid); end
    drain();
  endtask

  task automatic test_outstanding();
    logic [ENT_W-1:0] e;
    logic exp_g;
    cmd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      e = mk(i);
      drive_req(1'b1, e);
      #1;
      exp_g = (m_out < MAX_OUT);
      checks++; if (gnt !== exp_g) begin failures++; $display("FAIL outs_gnt[%0d]: got %b expected %b", i, gnt, exp_g); end
      checks++; if (cmd_valid !== exp_g || (exp_g && cmd_obs !== e)) begin failures++; $display("FAIL outs_cmd[%0d]: got valid=%b op=%h expected %b %h", i, cmd_valid, cmd_op, exp_g, e[OPS_W +: OP_W]); end
      if (exp_g) m_out++;
      step();
    end
    checks++; if (outstanding !== 4'd8) begin failures++; $display("FAIL outs_count: got %0d expected 8", outstanding); end
    drive_req(1'b0, '0);
    rsp_valid = 1'b1; rsp_result = 32'h0000_0077; rsp_flags = 5'h11;
    #1;
    checks++; if (gnt !== 1'b0) begin failures++; $display("FAIL outs_gnt_same_cycle: got %b expected 0", gnt); end
    step();
    rsp_valid = 1'b0;
    m_out--;
    last_result = 32'h0000_0077;
    checks++; if (gnt !== 1'b1) begin failures++; $display("FAIL outs_gnt_after_rsp: got %b expected 1", gnt); end
    checks++; if (outstanding !== 4'd7) begin failures++; $display("FAIL outs_count_after: got %0d expected 7", outstanding); end
    checks++; if (rvalid !== 1'b1 || result !== 32'h0000_0077) begin failures++; $display("FAIL outs_rsp: got rvalid=%b result=%h expected 1 00000077", rvalid, result); end
    drain();
  endtask

  task automatic test_wrap();
    logic [ENT_W-1:0] e;
    logic exp_g;
    int sent = 0, next_op = 0, cyc = 0;
    while ((sent < 12 || cmd_q.size() > 0) && cyc < 100) begin
      cmd_ready = cyc[0];
      e = mk(sent);
      drive_req(sent < 12, e);
      rsp_valid = (m_out > 0);
      rsp_result = 32'h9000 + 32'(cyc);
      #1;
      exp_g = (cmd_q.size() < DEPTH) && (m_out < MAX_OUT);
      checks++; if (gnt !== exp_g) begin failures++; $display("FAIL wrap_gnt[c%0d]: got %b expected %b", cyc, gnt, exp_g); end
      if (rsp_valid) begin m_out--; last_result = rsp_result; end
      if (req && exp_g) begin cmd_q.push_back(e); sent++; m_out++; end
      if (cmd_q.size() > 0) begin
        checks++; if (cmd_valid !== 1'b1 || cmd_op !== 6'(next_op) || cmd_obs !== cmd_q[0]) begin failures++; $display("FAIL wrap_cmd[c%0d]: got valid=%b op=%0d expected 1 %0d", cyc, cmd_valid, cmd_op, next_op); end
        if (cmd_ready) begin void'(cmd_q.pop_front()); next_op++; end
      end else begin
        checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL wrap_idle[c%0d]: got valid=%b expected 0", cyc, cmd_valid); end
      end
      step();
      checks++; if (occupancy !== 3'(cmd_q.size()) || occupancy > 3'd4) begin failures++; $display("FAIL wrap_occ[c%0d]: got %0d expected %0d", cyc, occupancy, cmd_q.size()); end
      cyc++;
    end
    checks++; if (cyc >= 100 || next_op != 12) begin failures++; $display("FAIL wrap_done: got %0d commands in %0d cycles expected 12", next_op, cyc); end
    drive_req(1'b0, '0);
    cmd_q.delete();
    drain();
  endtask

  task automatic test_spurious();
    rsp_valid = 1'b1; rsp_result = 32'h0000_0BAD;
    step();
    rsp_valid = 1'b0;
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL spur_rvalid: got %b expected 0", rvalid); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL spur_err: got %b expected 1", err); end
    checks++; if (result !== last_result || outstanding !== 4'd0) begin failures++; $display("FAIL spur_hold: got result=%h out=%0d expected %h 0", result, outstanding, last_result); end
    repeat (3) step();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL spur_sticky: got %b expected 1", err); end
  endtask

  task automatic test_no_bypass();
    cmd_ready0 = 1'b1;
    req0 = 1'b1;
    {flags_i0, op0, operands0} = mk(42);
    #1;
    checks++; if (gnt0 !== 1'b1 || cmd_valid0 !== 1'b0) begin failures++; $display("FAIL nobyp_accept: got gnt=%b valid=%b expected 1 0", gnt0, cmd_valid0); end
    step();
    req0 = 1'b0;
    #1;
    checks++; if (cmd_valid0 !== 1'b1 || cmd_op0 !== 6'h2A || occupancy0 !== 3'd1) begin failures++; $display("FAIL nobyp_issue: got valid=%b op=%h occ=%0d expected 1 2a 1", cmd_valid0, cmd_op0, occupancy0); end
    step();
    checks++; if (cmd_valid0 !== 1'b0 || occupancy0 !== 3'd0 || outstanding0 !== 4'd1) begin failures++; $display("FAIL nobyp_after: got valid=%b occ=%0d out=%0d expected 0 0 1", cmd_valid0, occupancy0, outstanding0); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      cmd_ready = (i < 2);
      drive_req(1'b1, mk(30 + i));
      step();
    end
    drive_req(1'b0, '0);
    cmd_ready = 1'b0;
    #1;
    checks++; if (occupancy !== 3'd3 || outstanding !== 4'd5) begin failures++; $display("FAIL mid_before: got occ=%0d out=%0d expected 3 5", occupancy, outstanding); end
    n_reset = 1'b0;
    #1;
    checks++; if (occupancy !== 3'd0 || outstanding !== 4'd0 || outstanding0 !== 4'd0) begin failures++; $display("FAIL mid_counts: got occ=%0d out=%0d out0=%0d expected 0 0 0", occupancy, outstanding, outstanding0); end
    checks++; if ({rvalid, result, flags_o, err, cmd_valid} !== '0) begin failures++; $display("FAIL mid_outputs: got rvalid=%b result=%h flags=%h err=%b valid=%b expected all 0", rvalid, result, flags_o, err, cmd_valid); end
    #5 n_reset = 1'b1;
    step();
    checks++; if (gnt !== 1'b1 || occupancy !== 3'd0) begin failures++; $display("FAIL mid_release: got gnt=%b occ=%0d expected 1 0", gnt, occupancy); end
    cmd_q.delete();
    m_out = 0;
  endtask

  initial begin
    req = 1'b0; operands = '0; op = '0; flags_i = '0; cmd_ready = 1'b0;
    rsp_valid = 1'b0; rsp_result = '0; rsp_flags = '0;
    req0 = 1'b0; operands0 = '0; op0 = '0; flags_i0 = '0; cmd_ready0 = 1'b0;
    test_reset();
    test_bypass();
    test_fill();
    test_outstanding();
    test_wrap();
    test_spurious();
    test_no_bypass();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
